store_narrow_unit: RTL and testbench
====================================

Name: store_narrow_unit

Overview:
- Store-side counterpart of the datapath's immediate/load sign-extension logic. The extension path widens narrow values to 32 bits; this block narrows 32-bit register data to byte, halfword or word and writes it to a byte-wide data memory port.
- One byte is written per cycle over a valid/ready request handshake.
- It flags when narrowing loses information, i.e. when the stored value would not sign-extend back to the source register.
- It sits between the MEM-stage store logic and the byte-wide data RAM.

Parameters:
- ADDR_W, 32, width of request and memory addresses.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  1  store request present.
- req_ready  out  1  block can accept a request; registered.
- req_addr  in  ADDR_W  byte address of the store.
- req_data  in  32  source register value.
- req_size  in  2  00 byte, 01 halfword, 10 word, 11 illegal.
- mem_we  out  1  byte write strobe; registered.
- mem_addr  out  ADDR_W  byte address of the current write; registered.
- mem_wdata  out  8  byte being written; registered.
- mem_ready  in  1  memory accepts the write this cycle.
- done  out  1  one-cycle pulse when the request completes.
- err  out  1  valid with done: misaligned address or illegal size.
- ovf  out  1  valid with done: narrowing was lossy.

Behaviour:
- Reset (rst_n low, asynchronous):
  - State goes to IDLE.
  - req_ready, mem_we, done, err and ovf are 0; mem_addr and mem_wdata are 0.
  - req_ready rises at the first clock edge after rst_n deasserts.
- Reset mid-operation abandons the request. Bytes already written are not undone, and no done pulse is issued.
- States:
  - IDLE: req_ready=1.
  - WRITE: mem_we=1.
  - DONE: done=1 for exactly one cycle.
- Accept: a request is accepted when req_valid and req_ready are both 1 at a clock edge. addr, data and size are latched, and req_ready drops on that same edge. Request inputs are ignored outside IDLE.
- Byte count N: 1 for byte, 2 for halfword, 4 for word.
- Alignment:
  - Halfword requires addr[0]=0.
  - Word requires addr[1:0]=00.
  - A violation, or size 11, moves IDLE to DONE directly with err=1 and ovf=0. No mem_we is issued.
- Byte order is little-endian: byte k goes to addr+k with data[8k+7:8k], for k=0..N-1, in ascending order.
- Write sequencing:
  - IDLE to WRITE on a legal accept. mem_we, mem_addr=addr and mem_wdata=byte 0 are valid on the first cycle after the accept edge.
  - A byte transfers when mem_we and mem_ready are both 1 at a clock edge. The counter then advances and mem_addr/mem_wdata update to the next byte on that edge.
  - If mem_ready is 0, the outputs hold stable (stall of any length).
  - After the last byte transfers, state goes WRITE to DONE and mem_we drops on that edge.
- DONE: done=1 for one cycle with err/ovf valid, then IDLE with req_ready=1. err and ovf return to 0 with done.
- Latency with mem_ready held at 1: done asserts N+1 cycles after the accept edge. Back-to-back throughput is one request per N+2 cycles.
- Overflow is computed from the latched data:
  - byte: ovf=1 iff data[31:8] is not all copies of data[7].
  - halfword: ovf=1 iff data[31:16] is not all copies of data[15].
  - word: ovf=0.
  - ovf is reported but does not suppress the write.
- Address arithmetic is modulo 2^ADDR_W, so addr+k wraps past the all-ones address.
- Never more than N strobes per request. mem_we is never 1 in IDLE or DONE.

Test Plan:
1. Word store, addr=0x100, data=0xDEADBEEF, mem_ready=1 -> writes (0x100,EF), (0x101,BE), (0x102,AD), (0x103,DE) on consecutive cycles; done at accept+5 with err=0, ovf=0.
2. Byte store, data=0xFFFFFF80 then 0x00000180, addr=0x7 -> first: one write (0x7,0x80), ovf=0; second: one write (0x7,0x80), ovf=1.
3. Halfword store, addr=0x202, data=0x00008001, mem_ready low for 3 cycles on the second byte -> (0x202,01), then (0x203,80) held stable for 3 stall cycles; ovf=1; exactly 2 strobes.
4. Misaligned word at addr=0x102 and illegal size 11 -> no mem_we; done with err=1 at accept+1; req_ready back to 1 the next cycle.
5. Reset asserted mid-word after 2 bytes written -> outputs 0 immediately (asynchronous), no done; after release, req_ready=1 on the first edge and a new byte store completes normally.
6. Wrap: word store at addr=0xFFFFFFFC -> addresses FC, FD, FE, FF; halfword at 0xFFFFFFFE -> FE, FF; req_valid held high during WRITE does not cause a second accept.

Source files
------------

// File: rtl/store_narrow_unit.sv
// store_narrow_unit: narrows 32-bit store data to byte/half/word and writes it
// one byte per cycle, flagging misalignment and lossy narrowing.
module store_narrow_unit #(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_data,
    input  logic [1:0]        req_size,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    input  logic              mem_ready,
    output logic              done,
    output logic              err,
    output logic              ovf
);
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] WRITE = 2'd1;
    localparam logic [1:0] DONE  = 2'd2;

    logic [1:0]        state_q, state_d;
    logic [1:0]        cnt_q, cnt_d;
    logic [1:0]        size_q, size_d;
    logic [31:0]       data_q, data_d;
    logic              ready_q, ready_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] maddr_q, maddr_d;
    logic [7:0]        wdata_q, wdata_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
    logic              ovf_q, ovf_d;

    logic       accept, illegal, xfer, lossy;
    logic [1:0] last_idx, nxt;

    assign accept   = (state_q == IDLE) && req_valid && ready_q;
    assign illegal  = (req_size == 2'b11) || (req_size == 2'b01 && req_addr[0]) ||
                      (req_size == 2'b10 && |req_addr[1:0]);
    assign xfer     = we_q && mem_ready;
    // byte -> 0, half -> 1, word -> 3
    assign last_idx = {size_q[1], |size_q};
    assign nxt      = cnt_q + 2'd1;
    assign lossy    = (size_q == 2'b00) ? (data_q[31:8] != {24{data_q[7]}}) :
                      (size_q == 2'b01) ? (data_q[31:16] != {16{data_q[15]}}) : 1'b0;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        size_d  = size_q;
        data_d  = data_q;
        ready_d = ready_q;
        we_d    = we_q;
        maddr_d = maddr_q;
        wdata_d = wdata_q;
        done_d  = done_q;
        err_d   = err_q;
        ovf_d   = ovf_q;
        case (state_q)
            IDLE: begin
                ready_d = !accept;
                if (accept) begin
                    data_d = req_data;
                    size_d = req_size;
                    cnt_d  = 2'd0;
                    if (illegal) begin
                        state_d = DONE;
                        done_d  = 1'b1;
                        err_d   = 1'b1;
                        ovf_d   = 1'b0;
                    end else begin
                        state_d = WRITE;
                        we_d    = 1'b1;
                        maddr_d = req_addr;
                        wdata_d = req_data[7:0];
                    end
                end
            end
            WRITE: begin
                if (xfer) begin
                    if (cnt_q == last_idx) begin
                        state_d = DONE;
                        we_d    = 1'b0;
                        done_d  = 1'b1;
                        err_d   = 1'b0;
                        ovf_d   = lossy;
                    end else begin
                        cnt_d   = nxt;
                        maddr_d = maddr_q + ADDR_W'(1);
                        wdata_d = data_q[{nxt, 3'b000} +: 8];
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
                done_d  = 1'b0;
                err_d   = 1'b0;
                ovf_d   = 1'b0;
                ready_d = 1'b1;
            end
            default: begin
                state_d = IDLE;
                we_d    = 1'b0;
                done_d  = 1'b0;
                err_d   = 1'b0;
                ovf_d   = 1'b0;
                ready_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            size_q  <= '0;
            data_q  <= '0;
            ready_q <= 1'b0;
            we_q    <= 1'b0;
            maddr_q <= '0;
            wdata_q <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            size_q  <= size_d;
            data_q  <= data_d;
            ready_q <= ready_d;
            we_q    <= we_d;
            maddr_q <= maddr_d;
            wdata_q <= wdata_d;
            done_q  <= done_d;
            err_q   <= err_d;
            ovf_q   <= ovf_d;
        end
    end

    assign req_ready = ready_q;
    assign mem_we    = we_q;
    assign mem_addr  = maddr_q;
    assign mem_wdata = wdata_q;
    assign done      = done_q;
    assign err       = err_q;
    assign ovf       = ovf_q;
endmodule

// File: tb/tb_store_narrow_unit.sv
// tb_store_narrow_unit: directed checks of store_narrow_unit with
// hand-computed expected writes, flags and timing.
module tb_store_narrow_unit;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [31:0] req_addr = '0;
    logic [31:0] req_data = '0;
    logic [1:0]  req_size = '0;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic        mem_ready = 1'b1;
    logic        done, err, ovf;

    int tests = 0;
    int fails = 0;
    int xfers = 0;
    int base  = 0;

    store_narrow_unit #(.ADDR_W(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_addr(req_addr), .req_data(req_data), .req_size(req_size),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ready(mem_ready),
        .done(done), .err(err), .ovf(ovf)
    );

    always #5 clk = ~clk;

    always @(posedge clk)
        if (rst_n && mem_we && mem_ready) xfers <= xfers + 1;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_w(input string tag, input logic [31:0] a, input logic [7:0] d);
        chk({tag, ".we"}, 64'(mem_we), 64'd1);
        chk({tag, ".addr"}, 64'(mem_addr), 64'(a));
        chk({tag, ".data"}, 64'(mem_wdata), 64'(d));
        chk({tag, ".done"}, 64'(done), 64'd0);
    endtask

    task automatic chk_d(input string tag, input logic e, input logic o);
        chk({tag, ".done"}, 64'(done), 64'd1);
        chk({tag, ".err"}, 64'(err), 64'(e));
        chk({tag, ".ovf"}, 64'(ovf), 64'(o));
        chk({tag, ".we"}, 64'(mem_we), 64'd0);
        chk({tag, ".rdy"}, 64'(req_ready), 64'd0);
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, ".rdy"}, 64'(req_ready), 64'd1);
        chk({tag, ".done"}, 64'(done), 64'd0);
        chk({tag, ".err"}, 64'(err), 64'd0);
        chk({tag, ".ovf"}, 64'(ovf), 64'd0);
        chk({tag, ".we"}, 64'(mem_we), 64'd0);
    endtask

    task automatic req(input logic [31:0] a, input logic [31:0] d, input logic [1:0] s);
        req_valid = 1'b1;
        req_addr  = a;
        req_data  = d;
        req_size  = s;
    endtask

    initial begin
        #12;
        chk("rst.outs", {req_ready, mem_we, done, err, ovf, mem_addr, mem_wdata}, 64'd0);
        rst_n = 1'b1;
        tick;
        chk_idle("rst.release");

        // 1: word store, little-endian
        base = xfers;
        req(32'h100, 32'hDEADBEEF, 2'b10);
        tick;
        req_valid = 1'b0;
        chk("w.rdy_drop", 64'(req_ready), 64'd0);
        chk_w("w.b0", 32'h100, 8'hEF);
        tick; chk_w("w.b1", 32'h101, 8'hBE);
        tick; chk_w("w.b2", 32'h102, 8'hAD);
        tick; chk_w("w.b3", 32'h103, 8'hDE);
        tick; chk_d("w.done", 1'b0, 1'b0);
        chk("w.strobes", 64'(xfers - base), 64'd4);
        tick; chk_idle("w.idle");

        // 2: byte stores, lossless then lossy
        req(32'h7, 32'hFFFFFF80, 2'b00);
        tick;
        req_valid = 1'b0;
        chk_w("b1.b0", 32'h7, 8'h80);
        tick; chk_d("b1.done", 1'b0, 1'b0);
        tick; chk_idle("b1.idle");
        req(32'h7, 32'h00000180, 2'b00);
        tick;
        req_valid = 1'b0;
        chk_w("b2.b0", 32'h7, 8'h80);
        tick; chk_d("b2.done", 1'b0, 1'b1);
        tick; chk_idle("b2.idle");

        // 3: halfword with a stall on the second byte
        base = xfers;
        req(32'h202, 32'h00008001, 2'b01);
        tick;
        req_valid = 1'b0;
        chk_w("h.b0", 32'h202, 8'h01);
        tick; chk_w("h.b1", 32'h203, 8'h80);
        mem_ready = 1'b0;
        tick; chk_w("h.stall0", 32'h203, 8'h80);
        tick; chk_w("h.stall1", 32'h203, 8'h80);
        tick; chk_w("h.stall2", 32'h203, 8'h80);
        mem_ready = 1'b1;
        tick; chk_d("h.done", 1'b0, 1'b1);
        chk("h.strobes", 64'(xfers - base), 64'd2);
        tick; chk_idle("h.idle");

        // 4: misaligned word and illegal size
        base = xfers;
        req(32'h102, 32'h12345678, 2'b10);
        tick;
        req_valid = 1'b0;
        chk_d("mis.done", 1'b1, 1'b0);
        tick; chk_idle("mis.idle");
        req(32'h0, 32'hFFFFFFFF, 2'b11);
        tick;
        req_valid = 1'b0;
        chk_d("ill.done", 1'b1, 1'b0);
        tick; chk_idle("ill.idle");
        chk("err.strobes", 64'(xfers - base), 64'd0);

        // 5: asynchronous reset mid-word
        req(32'h40, 32'h11223344, 2'b10);
        tick;
        req_valid = 1'b0;
        chk_w("r.b0", 32'h40, 8'h44);
        tick; chk_w("r.b1", 32'h41, 8'h33);
        tick; chk_w("r.b2", 32'h42, 8'h22);
        #2 rst_n = 1'b0;
        #1;
        chk("r.async", {req_ready, mem_we, done, err, ovf, mem_addr, mem_wdata}, 64'd0);
        tick;
        chk("r.held", {req_ready, mem_we, done, err, ovf, mem_addr, mem_wdata}, 64'd0);
        rst_n = 1'b1;
        tick; chk_idle("r.release");
        req(32'h5, 32'h0000007F, 2'b00);
        tick;
        req_valid = 1'b0;
        chk_w("r.new", 32'h5, 8'h7F);
        tick; chk_d("r.new_done", 1'b0, 1'b0);
        tick; chk_idle("r.new_idle");

        // 6: top-of-address-space stores with req_valid held high
        base = xfers;
        req(32'hFFFFFFFC, 32'hA1B2C3D4, 2'b10);
        tick; chk_w("wr.b0", 32'hFFFFFFFC, 8'hD4);
        tick; chk_w("wr.b1", 32'hFFFFFFFD, 8'hC3);
        tick; chk_w("wr.b2", 32'hFFFFFFFE, 8'hB2);
        tick; chk_w("wr.b3", 32'hFFFFFFFF, 8'hA1);
        tick; chk_d("wr.done", 1'b0, 1'b0);
        chk("wr.strobes", 64'(xfers - base), 64'd4);
        base = xfers;
        req(32'hFFFFFFFE, 32'h00001234, 2'b01);
        tick; chk_idle("wr.idle");
        tick;
        req_valid = 1'b0;
        chk_w("hw.b0", 32'hFFFFFFFE, 8'h34);
        tick; chk_w("hw.b1", 32'hFFFFFFFF, 8'h12);
        tick; chk_d("hw.done", 1'b0, 1'b0);
        chk("hw.strobes", 64'(xfers - base), 64'd2);
        tick; chk_idle("hw.idle");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
